// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: decode hazard flags -> hold/bubble/flush/redirect,
// plus mul/div wait sequencing, trap entry/exit and a saturating stall counter.
//
// state     | meaning
// ST_RUN    | normal issue; outputs decoded combinationally from decode flags
// ST_MDWAIT | mul/div in flight; front end held until md_done or timeout
// ST_TRAP   | one cycle after trap entry; redirect fetch to the latched vector
module pipe_hazard_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             de_inst_valid,
   input  logic             de_ld_stall,
   input  logic             de_st_ld_conf,
   input  logic             de_br_err,
   input  logic [31:0]      de_br_target,
   input  logic             de_md_op,
   input  logic             de_exp,
   input  logic             de_e_bk,
   input  logic             de_mret,
   input  logic [31:0]      de_pc,
   input  logic             irq,
   input  logic             mie,
   input  logic [31:0]      csr_mtvec,
   input  logic [31:0]      csr_mepc,
   input  logic             md_done,
   output logic             fe_hold,
   output logic             de_hold,
   output logic             ex_bubble,
   output logic             fe_flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             md_start,
   output logic             md_abort,
   output logic             trap_take,
   output logic [31:0]      trap_mepc,
   output logic [31:0]      trap_mcause,
   output logic             mret_take,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(MD_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_MDWAIT = 2'd1,
      ST_TRAP   = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [31:0]   vec, vec_nxt;
   logic          irq_take;

   assign irq_take = irq & mie;

   always_comb begin
      state_nxt      = state;
      tmr_nxt        = tmr;
      vec_nxt        = vec;
      fe_hold        = 1'b0;
      de_hold        = 1'b0;
      ex_bubble      = 1'b0;
      fe_flush       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      md_start       = 1'b0;
      md_abort       = 1'b0;
      trap_take      = 1'b0;
      trap_mepc      = '0;
      trap_mcause    = '0;
      mret_take      = 1'b0;

      case (state)
         ST_RUN: begin
            if (de_inst_valid) begin
               if (de_exp || irq_take) begin
                  trap_take = 1'b1;
                  trap_mepc = de_pc;
                  ex_bubble = 1'b1;
                  fe_flush  = 1'b1;
                  fe_hold   = 1'b1;
                  // an interrupt outranks a coincident ecall/ebreak
                  if (irq_take)
                     trap_mcause = 32'h8000_000B;
                  else if (de_e_bk)
                     trap_mcause = 32'd3;
                  else
                     trap_mcause = 32'd11;
                  vec_nxt   = {csr_mtvec[31:2], 2'b00};
                  state_nxt = ST_TRAP;
               end else if (de_mret) begin
                  mret_take      = 1'b1;
                  redirect_valid = 1'b1;
                  redirect_pc    = csr_mepc;
                  fe_flush       = 1'b1;
                  ex_bubble      = 1'b1;
               end else if (de_br_err) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = de_br_target;
                  fe_flush       = 1'b1;
               end else if (de_ld_stall || de_st_ld_conf) begin
                  fe_hold   = 1'b1;
                  de_hold   = 1'b1;
                  ex_bubble = 1'b1;
               end else if (de_md_op) begin
                  md_start  = 1'b1;
                  tmr_nxt   = TMR_LOAD;
                  state_nxt = ST_MDWAIT;
               end
            end
         end
         ST_MDWAIT: begin
            if (md_done) begin
               state_nxt = ST_RUN;
            end else begin
               fe_hold = 1'b1;
               de_hold = 1'b1;
               if (tmr == '0) begin
                  md_abort  = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  tmr_nxt = tmr - TW'(1);
               end
            end
         end
         ST_TRAP: begin
            redirect_valid = 1'b1;
            redirect_pc    = vec;
            fe_flush       = 1'b1;
            ex_bubble      = 1'b1;
            state_nxt      = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase

      // RUN decode is combinational, so reset must also mask it
      if (!rst_n) begin
         fe_hold        = 1'b0;
         de_hold        = 1'b0;
         ex_bubble      = 1'b0;
         fe_flush       = 1'b0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         md_start       = 1'b0;
         md_abort       = 1'b0;
         trap_take      = 1'b0;
         trap_mepc      = '0;
         trap_mcause    = '0;
         mret_take      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         tmr       <= '0;
         vec       <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         vec   <= vec_nxt;
         if (fe_hold && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: cycle model checked every negedge plus directed
// literal expectations. Narrow stall counter so saturation is reachable.
module tb_pipe_hazard_ctrl;

   localparam int MD_TIMEOUT = 64;
   localparam int CNT_W      = 8;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             de_inst_valid, de_ld_stall, de_st_ld_conf, de_br_err;
   logic [31:0]      de_br_target;
   logic             de_md_op, de_exp, de_e_bk, de_mret;
   logic [31:0]      de_pc;
   logic             irq, mie;
   logic [31:0]      csr_mtvec, csr_mepc;
   logic             md_done;
   logic             fe_hold, de_hold, ex_bubble, fe_flush, redirect_valid;
   logic [31:0]      redirect_pc;
   logic             md_start, md_abort, trap_take;
   logic [31:0]      trap_mepc, trap_mcause;
   logic             mret_take;
   logic [CNT_W-1:0] stall_cnt;

   int n_chk = 0;
   int n_err = 0;

   pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .de_inst_valid(de_inst_valid), .de_ld_stall(de_ld_stall),
      .de_st_ld_conf(de_st_ld_conf), .de_br_err(de_br_err),
      .de_br_target(de_br_target), .de_md_op(de_md_op), .de_exp(de_exp),
      .de_e_bk(de_e_bk), .de_mret(de_mret), .de_pc(de_pc), .irq(irq),
      .mie(mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
      .md_done(md_done), .fe_hold(fe_hold), .de_hold(de_hold),
      .ex_bubble(ex_bubble), .fe_flush(fe_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .md_start(md_start), .md_abort(md_abort), .trap_take(trap_take),
      .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
      .mret_take(mret_take), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
      end
   endtask

   // Model: mode 0=running, 1=waiting on mul/div, 2=redirecting after trap
   int          m_mode  = 0;
   int          m_waited = 0;
   logic [31:0] m_vec   = '0;
   int          m_stall = 0;

   always @(negedge clk) begin
      logic [8:0]  e_flags;
      logic        e_feh, e_deh, e_bub, e_fl, e_rv, e_st, e_ab, e_tt, e_mr;
      logic [31:0] e_rpc, e_mepc, e_cause;
      int          nxt;
      {e_feh, e_deh, e_bub, e_fl, e_rv, e_st, e_ab, e_tt, e_mr} = '0;
      e_rpc = '0; e_mepc = '0; e_cause = '0;
      nxt = m_mode;
      if (!rst_n) begin
         m_mode = 0; m_waited = 0; m_stall = 0; nxt = 0;
      end else if (m_mode == 0) begin
         if (de_inst_valid) begin
            if (de_exp || (irq && mie)) begin
               e_tt = 1; e_mepc = de_pc; e_bub = 1; e_fl = 1; e_feh = 1;
               e_cause = (irq && mie) ? 32'h8000000B : (de_e_bk ? 32'd3 : 32'd11);
               m_vec = csr_mtvec & 32'hFFFF_FFFC;
               nxt = 2;
            end else if (de_mret) begin
               e_mr = 1; e_rv = 1; e_rpc = csr_mepc; e_fl = 1; e_bub = 1;
            end else if (de_br_err) begin
               e_rv = 1; e_rpc = de_br_target; e_fl = 1;
            end else if (de_ld_stall || de_st_ld_conf) begin
               e_feh = 1; e_deh = 1; e_bub = 1;
            end else if (de_md_op) begin
               e_st = 1; m_waited = 0; nxt = 1;
            end
         end
      end else if (m_mode == 1) begin
         if (md_done) begin
            nxt = 0;
         end else begin
            e_feh = 1; e_deh = 1;
            if (m_waited == MD_TIMEOUT - 1) begin
               e_ab = 1; nxt = 0;
            end else begin
               m_waited++;
            end
         end
      end else begin
         e_rv = 1; e_rpc = m_vec; e_fl = 1; e_bub = 1; nxt = 0;
      end
      e_flags = {e_feh, e_deh, e_bub, e_fl, e_rv, e_st, e_ab, e_tt, e_mr};
      chk("model_flags", {23'd0, fe_hold, de_hold, ex_bubble, fe_flush, redirect_valid,
                          md_start, md_abort, trap_take, mret_take}, {23'd0, e_flags});
      chk("model_redirect_pc", redirect_pc, e_rpc);
      chk("model_trap_mepc", trap_mepc, e_mepc);
      chk("model_trap_mcause", trap_mcause, e_cause);
      chk("model_stall_cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, 32'(m_stall));
      if (rst_n && e_feh && m_stall < CNT_MAX) m_stall++;
      m_mode = nxt;
   end

   task automatic clr();
      de_inst_valid = 0; de_ld_stall = 0; de_st_ld_conf = 0; de_br_err = 0;
      de_br_target = '0; de_md_op = 0; de_exp = 0; de_e_bk = 0; de_mret = 0;
      de_pc = '0; irq = 0; mie = 0; md_done = 0;
   endtask
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic look();
      @(negedge clk); #1;
   endtask

   task automatic md_timeout_run(input string nm);
      int  n;
      bit  got;
      n = 0; got = 0;
      de_inst_valid = 1; de_md_op = 1;
      look(); chk({nm, "_start"}, 32'(md_start), 32'd1);
      tick(); clr();
      for (int i = 0; i < 100 && !got; i++) begin
         look(); n++;
         if (md_abort) got = 1;
         tick();
      end
      chk({nm, "_abort_cycle"}, 32'(n), 32'd64);
   endtask

   initial begin
      clr();
      csr_mtvec = 32'h0000_0201; csr_mepc = 32'h0000_0444;
      rst_n = 0;
      de_inst_valid = 1; de_br_err = 1; de_br_target = 32'h80; de_exp = 1;
      look();
      chk("rst_redirect", 32'(redirect_valid), 32'd0);
      chk("rst_trap", 32'(trap_take), 32'd0);
      chk("rst_fe_hold", 32'(fe_hold), 32'd0);
      tick(); tick();
      clr(); rst_n = 1;
      look(); chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();

      de_inst_valid = 1; de_ld_stall = 1;
      look();
      chk("ld_fe_hold", 32'(fe_hold), 32'd1);
      chk("ld_de_hold", 32'(de_hold), 32'd1);
      chk("ld_bubble", 32'(ex_bubble), 32'd1);
      tick(); clr();
      look();
      chk("ld_release", 32'(fe_hold), 32'd0);
      chk("ld_stall_cnt", 32'(stall_cnt), 32'd1);
      tick();

      de_inst_valid = 1; de_br_err = 1; de_br_target = 32'h80;
      look();
      chk("br_valid", 32'(redirect_valid), 32'd1);
      chk("br_pc", redirect_pc, 32'h80);
      chk("br_flush", 32'(fe_flush), 32'd1);
      chk("br_no_bubble", 32'(ex_bubble), 32'd0);
      tick(); clr();

      de_inst_valid = 1; de_md_op = 1;
      look(); chk("md_start", 32'(md_start), 32'd1);
      tick(); clr();
      for (int i = 0; i < 5; i++) begin
         look(); chk("md_wait_hold", 32'(de_hold), 32'd1);
         tick();
      end
      md_done = 1;
      look();
      chk("md_done_drop", 32'(fe_hold), 32'd0);
      chk("md_done_no_abort", 32'(md_abort), 32'd0);
      tick(); clr();
      look(); chk("md_done_stall_cnt", 32'(stall_cnt), 32'd6);
      tick();

      md_timeout_run("md_to");
      look();
      chk("md_to_stall_cnt", 32'(stall_cnt), 32'd70);
      chk("md_to_back_run", 32'(fe_hold), 32'd0);
      tick();

      de_inst_valid = 1; de_exp = 1; de_pc = 32'h100;
      look();
      chk("ecall_take", 32'(trap_take), 32'd1);
      chk("ecall_mepc", trap_mepc, 32'h100);
      chk("ecall_cause", trap_mcause, 32'd11);
      tick(); clr();
      look();
      chk("ecall_redirect", 32'(redirect_valid), 32'd1);
      chk("ecall_vec", redirect_pc, 32'h200);
      tick();

      de_inst_valid = 1; de_exp = 1; de_e_bk = 1; de_pc = 32'h104;
      look(); chk("ebreak_cause", trap_mcause, 32'd3);
      tick(); clr(); tick();

      de_inst_valid = 1; de_mret = 1;
      look();
      chk("mret_take", 32'(mret_take), 32'd1);
      chk("mret_pc", redirect_pc, 32'h444);
      tick(); clr();

      de_inst_valid = 1; irq = 1; mie = 1; de_br_err = 1; de_br_target = 32'h80; de_pc = 32'h300;
      look();
      chk("irq_take", 32'(trap_take), 32'd1);
      chk("irq_cause", trap_mcause, 32'h8000_000B);
      chk("irq_no_branch", 32'(redirect_valid), 32'd0);
      tick(); clr();
      look(); chk("irq_vec", redirect_pc, 32'h200);
      tick();

      de_inst_valid = 1; irq = 1; mie = 0;
      look(); chk("irq_masked", 32'(trap_take), 32'd0);
      tick();
      de_inst_valid = 0; mie = 1;
      look(); chk("irq_no_valid", 32'(trap_take), 32'd0);
      tick(); clr();

      de_inst_valid = 1; de_md_op = 1;
      tick(); clr();
      de_inst_valid = 1; irq = 1; mie = 1;
      look(); chk("irq_in_wait", 32'(trap_take), 32'd0);
      tick(); tick();
      md_done = 1;
      tick(); md_done = 0;
      look(); chk("irq_after_wait", 32'(trap_take), 32'd1);
      tick(); clr();
      look(); chk("irq_wait_stall_cnt", 32'(stall_cnt), 32'd76);
      tick();

      de_inst_valid = 1; de_exp = 1; de_pc = 32'h500;
      tick(); clr();
      rst_n = 0;
      look();
      chk("rst_in_trap_redirect", 32'(redirect_valid), 32'd0);
      chk("rst_in_trap_pc", redirect_pc, 32'd0);
      chk("rst_in_trap_cnt", 32'(stall_cnt), 32'd0);
      tick(); rst_n = 1;
      tick();

      de_inst_valid = 1; de_md_op = 1;
      tick(); clr(); tick();
      rst_n = 0;
      look();
      chk("rst_in_wait_abort", 32'(md_abort), 32'd0);
      chk("rst_in_wait_hold", 32'(fe_hold), 32'd0);
      tick(); rst_n = 1;
      tick();

      for (int k = 0; k < 4; k++) md_timeout_run("sat");
      look(); chk("stall_saturate", 32'(stall_cnt), 32'(CNT_MAX));
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
